matrix_elem_sequencer: RTL and testbench
========================================

# matrix_elem_sequencer

Command-level sequencer that sits directly upstream of the matrix ALU. It accepts one matrix command and walks the row/column indices of an NxN matrix. For each element it issues synchronous reads to the A and B element memories, presents the operands to the ALU, and writes the ALU result into the C element memory. It handles element-wise ops (addM, subM, multMR, oppM), transM and the reset/clear op. multM and detM belong to a separate block; this block rejects them.

## Interface
- DW, 8, element width (matches ALU operands)
- AW, 5, element memory address width
- STRIDE, 5, fixed row stride; addr = row*STRIDE + col
- MAXN, 5, largest supported matrix dimension
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe, sampled only in IDLE
- op  in  3  ALU opcode: 000 add, 001 sub, 010 mult, 011 multR, 100 det, 101 trans, 110 opp, 111 reset
- size  in  3  matrix dimension N
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for a rejected command
- a_raddr, b_raddr  out  AW  registered read addresses
- a_rdata, b_rdata  in  DW  read data, valid one cycle after the address
- alu_op, alu_s  out  3  latched op and size
- alu_r1, alu_r2  out  DW  driven combinationally from a_rdata and b_rdata
- alu_result  in  DW  combinational ALU output
- c_we  out  1  C write enable
- c_waddr  out  AW  C write address
- c_wdata  out  DW  C write data

## Operation
- States:
  - IDLE: start=1 moves to CHECK.
  - CHECK: legal commands move to RUN; illegal commands move to DONE with err.
  - RUN: issues one element address per cycle.
  - DRAIN: waits 2 cycles for the pipeline to empty.
  - DONE: 1 cycle, then back to IDLE.
- Latch on accept: op, size. start is ignored while not in IDLE.
- Illegal command: op=010, op=100, or (op!=111 and size not in 2..MAXN). It produces no reads and no writes.
- Index counters:
  - row and col start at 0 and advance row-major.
  - When col reaches N-1, col wraps to 0 and row increments.
  - The last element is row=col=N-1; RUN then moves to DRAIN.
- Address rules:
  - Default: a_raddr = b_raddr = c_waddr = row*STRIDE+col.
  - transM: a_raddr = col*STRIDE+row.
  - multMR: b_raddr is held at 0, so the scalar is B[0].
  - oppM: b_raddr is don't-care; 0 is driven.
- reset op (111): ignores size and the ALU. It writes c_wdata=0 to every address row*STRIDE+col for a MAXN x MAXN walk, i.e. 25 writes to addresses 0..24.
- Pipeline, with element k's address issued in cycle t:
  - Cycle t+1: rdata is valid and the ALU evaluates.
  - End of cycle t+1: alu_result and the delayed write address are registered.
  - Cycle t+2: c_we=1.
- Write address and valid travel in a 2-deep shift register alongside the read.
- Arithmetic: the block performs none; the result is DW bits from the ALU and is written as-is.

## Timing
- Reset values: busy=0, done=0, err=0, c_we=0, all addresses 0, c_wdata=0, alu_op=0, alu_s=0, state IDLE.
- Command cycles, with start sampled at edge E0 (cycle 0 = the cycle in which start=1 is sampled):
  - CHECK occupies cycle 1.
  - Element k's address appears in cycle 2+k.
  - c_we for element k is high in cycle 4+k.
  - With M elements (N² normally, 25 for reset), done is high in cycle M+4, and busy is low in that same cycle.
- busy is high from cycle 1 through cycle M+3.
- Rejected command: busy is high in cycle 1 only; done=err=1 in cycle 2.
- c_we is asserted on exactly M consecutive cycles with no bubbles.
- rst_n low mid-command: all outputs return to reset values asynchronously and c_we drops immediately. No partial-write recovery is performed. The next start after reset release behaves normally.
- start held high across done: a new command is accepted only in the cycle after DONE returns to IDLE.

## Structure
- Shared package matrix_pkg holds:
  - opcode localparams (OP_ADD..OP_RST)
  - DW, AW, STRIDE, MAXN
  - the state enum
- The ALU uses the same opcode constants.
- Sub-module matrix_index_counter holds the row/col counters. It has load, advance and transpose inputs, and outputs addr, taddr and last.
- The top level holds the FSM, the legality check and the 2-stage write pipeline.

## Test plan
- addM, N=2: A at addresses 0,1,5,6 = 1,2,3,4 and B = 10,20,30,40 → C writes (0,11),(1,22),(5,33),(6,44) in cycles 4..7; done in cycle 8.
- transM, N=3: A[r][c] = r*5+c → a_raddr sequence 0,5,10,1,6,11,2,7,12; C[r][c] = c*5+r.
- multMR, N=2: B[0]=3 → b_raddr=0 on all 4 read cycles; alu_op=011, alu_s=2.
- reset op with size=0 → 25 writes of value 0 to addresses 0..24 in order; done in cycle 29; no ALU dependency.
- Rejection cases:
  - op=010, N=3 → err=done=1 in cycle 2 and no c_we.
  - op=000, size=6 → same response.
  - op=000, size=1 → same response.
- addM, N=5: drop rst_n in cycle 6 → c_we, busy and done are 0 immediately. After reset release, a new N=2 addM completes correctly. A start pulsed during the killed command's busy window is ignored.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, opcodes and state encoding for the matrix element path.
// The ALU decodes the same opcode constants.
package matrix_pkg;

    localparam int DW     = 8;
    localparam int AW     = 5;
    localparam int STRIDE = 5;
    localparam int MAXN   = 5;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MULTR = 3'b011;
    localparam logic [2:0] OP_DET   = 3'b100;
    localparam logic [2:0] OP_TRANS = 3'b101;
    localparam logic [2:0] OP_OPP   = 3'b110;
    localparam logic [2:0] OP_RST   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [AW-1:0] elem_addr(
        input logic [2:0] r,
        input logic [2:0] c
    );
        return AW'(r) * AW'(STRIDE) + AW'(c);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker with registered straight and transposed addresses.
// Wraps back to (0,0) after the last element so idle addresses read as zero.
module matrix_index_counter
    import matrix_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          advance,
    input  logic          transpose,
    input  logic [2:0]    n,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] taddr,
    output logic          last
);

    logic [2:0] row, col, nm1;
    logic [2:0] row_n, col_n;
    logic       tr;

    assign last = (row == nm1) && (col == nm1);

    always_comb begin
        row_n = row;
        col_n = col;
        if (last) begin
            row_n = 3'd0;
            col_n = 3'd0;
        end else if (col == nm1) begin
            row_n = row + 3'd1;
            col_n = 3'd0;
        end else begin
            col_n = col + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            col   <= '0;
            nm1   <= '0;
            tr    <= 1'b0;
            addr  <= '0;
            taddr <= '0;
        end else if (load) begin
            row   <= '0;
            col   <= '0;
            nm1   <= n - 3'd1;
            tr    <= transpose;
            addr  <= '0;
            taddr <= '0;
        end else if (advance) begin
            row   <= row_n;
            col   <= col_n;
            addr  <= elem_addr(row_n, col_n);
            taddr <= tr ? elem_addr(col_n, row_n) : elem_addr(row_n, col_n);
        end
    end

endmodule

// File: rtl/matrix_elem_sequencer.sv
// Walks an NxN matrix, reading A/B, feeding the ALU and writing C two cycles later.
// Rejects multM/detM and out-of-range sizes without touching memory.
module matrix_elem_sequencer
    import matrix_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [2:0]    size,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] a_raddr,
    output logic [AW-1:0] b_raddr,
    input  logic [DW-1:0] a_rdata,
    input  logic [DW-1:0] b_rdata,
    output logic [2:0]    alu_op,
    output logic [2:0]    alu_s,
    output logic [DW-1:0] alu_r1,
    output logic [DW-1:0] alu_r2,
    input  logic [DW-1:0] alu_result,
    output logic          c_we,
    output logic [AW-1:0] c_waddr,
    output logic [DW-1:0] c_wdata
);

    state_t        state, state_n;
    logic          accept, legal, run, last, bzero;
    logic          rej_q, drain_q, v1;
    logic [AW-1:0] addr, taddr, wa1;
    logic [2:0]    cnt_n;

    assign accept = (state == S_IDLE) && start;
    assign run    = (state == S_RUN);
    assign cnt_n  = (op == OP_RST) ? 3'(MAXN) : size;
    assign legal  = !(alu_op == OP_MULT || alu_op == OP_DET ||
                      (alu_op != OP_RST &&
                       (alu_s < 3'd2 || alu_s > 3'(MAXN))));
    assign bzero  = (alu_op == OP_MULTR) || (alu_op == OP_OPP);

    assign a_raddr = taddr;
    assign b_raddr = bzero ? '0 : addr;
    assign alu_r1  = a_rdata;
    assign alu_r2  = b_rdata;

    matrix_index_counter u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (run),
        .transpose (op == OP_TRANS),
        .n         (cnt_n),
        .addr      (addr),
        .taddr     (taddr),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_CHECK;
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_n = legal ? S_RUN : S_DONE;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = rej_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op  <= '0;
            alu_s   <= '0;
            rej_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= op;
                alu_s  <= size;
            end
            if (state == S_CHECK) rej_q <= !legal;
            drain_q <= (state == S_DRAIN) && !drain_q;
        end
    end

    // Write address/valid ride two stages behind the read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            wa1     <= '0;
            c_we    <= 1'b0;
            c_waddr <= '0;
            c_wdata <= '0;
        end else begin
            v1      <= run;
            wa1     <= addr;
            c_we    <= v1;
            c_waddr <= wa1;
            if (v1) c_wdata <= (alu_op == OP_RST) ? '0 : alu_result;
        end
    end

endmodule

// File: tb/tb_matrix_elem_sequencer.sv
// Bench for matrix_elem_sequencer: memory and ALU models around the DUT,
// per-command expectations built from row/col arithmetic.
module tb_matrix_elem_sequencer;
    import matrix_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [2:0]    size = 3'd0;
    logic          busy, done, err;
    logic [AW-1:0] a_raddr, b_raddr;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [2:0]    alu_op, alu_s;
    logic [DW-1:0] alu_r1, alu_r2;
    logic [DW-1:0] alu_result;
    logic          c_we;
    logic [AW-1:0] c_waddr;
    logic [DW-1:0] c_wdata;

    logic [7:0] amem [32];
    logic [7:0] bmem [32];
    int total = 0;
    int bad = 0;
    int cap_a [$];
    int cap_d [$];

    matrix_elem_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .size       (size),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .a_raddr    (a_raddr),
        .b_raddr    (b_raddr),
        .a_rdata    (a_rdata),
        .b_rdata    (b_rdata),
        .alu_op     (alu_op),
        .alu_s      (alu_s),
        .alu_r1     (alu_r1),
        .alu_r2     (alu_r2),
        .alu_result (alu_result),
        .c_we       (c_we),
        .c_waddr    (c_waddr),
        .c_wdata    (c_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        a_rdata <= amem[a_raddr];
        b_rdata <= bmem[b_raddr];
    end

    // Stand-in ALU; the reset op gets a poison value to expose any dependency.
    always_comb begin
        alu_result = 8'hA5;
        case (alu_op)
            3'd0: alu_result = alu_r1 + alu_r2;
            3'd1: alu_result = alu_r1 - alu_r2;
            3'd3: alu_result = alu_r1 * alu_r2;
            3'd5: alu_result = alu_r1;
            3'd6: alu_result = 8'd0 - alu_r1;
            default: alu_result = 8'hA5;
        endcase
    end

    function automatic logic [7:0] ref_val(
        input logic [2:0] o,
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] b0
    );
        logic [7:0] v;
        v = 8'd0;
        case (o)
            3'd0: v = a + b;
            3'd1: v = a - b;
            3'd3: v = a * b0;
            3'd5: v = a;
            3'd6: v = 8'd0 - a;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 32; i++) begin
            amem[i] = 8'($urandom);
            bmem[i] = 8'($urandom);
        end
    endtask

    task automatic run_cmd(input logic [2:0] o, input logic [2:0] s, input bit rnd);
        int  n, m, edone, dcyc, nw, cyc, busy_err;
        bit  legal;
        int  ea [$];
        int  eb [$];
        int  ew [$];
        int  ed [$];
        if (rnd) rand_mem();
        legal = !(o == 3'd2 || o == 3'd4 || (o != 3'd7 && (s < 3'd2 || s > 3'd5)));
        n = (o == 3'd7) ? 5 : int'(s);
        m = legal ? n * n : 0;
        edone = legal ? m + 4 : 2;
        for (int k = 0; k < m; k++) begin
            int r, c, lin;
            r = k / n;
            c = k % n;
            lin = r * STRIDE + c;
            ea.push_back(o == 3'd5 ? c * STRIDE + r : lin);
            eb.push_back((o == 3'd3 || o == 3'd6) ? 0 : lin);
            ew.push_back(lin);
            ed.push_back(int'(ref_val(o, amem[ea[k]], bmem[lin], bmem[0])));
        end
        cap_a.delete();
        cap_d.delete();
        @(negedge clk);
        start = 1'b1;
        op = o;
        size = s;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        dcyc = -1;
        nw = 0;
        busy_err = 0;
        while (cyc < 60 && dcyc < 0) begin
            if (busy !== (cyc < edone)) busy_err++;
            if (legal && cyc == 2) begin
                chk("alu_op", 32'(alu_op), 32'(o));
                chk("alu_s", 32'(alu_s), 32'(s));
            end
            if (cyc >= 2 && cyc - 2 < m) begin
                chk("a_raddr", 32'(a_raddr), ea[cyc-2]);
                chk("b_raddr", 32'(b_raddr), eb[cyc-2]);
            end
            if (c_we === 1'b1) begin
                cap_a.push_back(int'(c_waddr));
                cap_d.push_back(int'(c_wdata));
                if (nw < m) begin
                    chk("we_cycle", cyc, 4 + nw);
                    chk("c_waddr", 32'(c_waddr), ew[nw]);
                    chk("c_wdata", 32'(c_wdata), ed[nw]);
                end
                nw++;
            end
            if (done === 1'b1) begin
                dcyc = cyc;
                chk("err", 32'(err), 32'(!legal));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_cycle", dcyc, edone);
        chk("write_count", nw, m);
        chk("busy_window", busy_err, 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(0));
    endtask

    initial begin
        logic [2:0] legal_ops [5];
        legal_ops = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd6};
        for (int i = 0; i < 32; i++) begin
            amem[i] = 8'd0;
            bmem[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(c_we), 0);
        chk("rst_araddr", 32'(a_raddr), 0);
        chk("rst_braddr", 32'(b_raddr), 0);
        chk("rst_waddr", 32'(c_waddr), 0);
        chk("rst_wdata", 32'(c_wdata), 0);
        chk("rst_aluop", 32'(alu_op), 0);
        chk("rst_alus", 32'(alu_s), 0);
        rst_n = 1'b1;

        amem[0] = 8'd1;  amem[1] = 8'd2;  amem[5] = 8'd3;  amem[6] = 8'd4;
        bmem[0] = 8'd10; bmem[1] = 8'd20; bmem[5] = 8'd30; bmem[6] = 8'd40;
        run_cmd(3'd0, 3'd2, 1'b0);
        chk("add_w0_data", cap_d[0], 11);
        chk("add_w3_addr", cap_a[3], 6);
        chk("add_w3_data", cap_d[3], 44);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                amem[r*5+c] = 8'(r * 5 + c);
        run_cmd(3'd5, 3'd3, 1'b0);
        chk("trans_w1_data", cap_d[1], 5);

        rand_mem();
        bmem[0] = 8'd3;
        run_cmd(3'd3, 3'd2, 1'b0);

        run_cmd(3'd7, 3'd0, 1'b1);
        chk("rst_last_addr", cap_a[24], 24);

        run_cmd(3'd2, 3'd3, 1'b1);
        run_cmd(3'd0, 3'd6, 1'b1);
        run_cmd(3'd0, 3'd1, 1'b1);
        run_cmd(3'd4, 3'd4, 1'b1);

        for (int i = 0; i < 8; i++)
            run_cmd(legal_ops[$urandom_range(0, 4)], 3'($urandom_range(2, 5)), 1'b1);

        rand_mem();
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        size = 3'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        op = 3'd0;
        chk("kill_start_ignored", 32'(alu_s), 32'(5));
        chk("kill_busy", 32'(busy), 32'(1));
        repeat (2) @(negedge clk);
        chk("kill_we_before", 32'(c_we), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("kill_we", 32'(c_we), 0);
        chk("kill_busy_low", 32'(busy), 0);
        chk("kill_done", 32'(done), 0);
        chk("kill_wdata", 32'(c_wdata), 0);
        chk("kill_aluop", 32'(alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd0, 3'd2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
